sram_1rw1r_wmask: RTL and testbench
===================================

// Module: sram_1rw1r_wmask
// PURPOSE
//  Parametrised synchronous SRAM model: port 0 read/write with per-slice write mask, port 1 read-only.
//  Adds synchronous reset, hardware zero-clear of the array after reset, read-valid flags and an optional output register.
//  Drop-in behavioural macro for datapath buffers and register files. Single clock domain.
// PARAMETERS
//  DATA_WIDTH   32   word width in bits; must be a multiple of WMASK_WIDTH
//  ADDR_WIDTH   7    address bits
//  RAM_DEPTH    1<<ADDR_WIDTH   number of words
//  WMASK_WIDTH  8    bits per write-mask slice
//  NUM_WMASKS   DATA_WIDTH/WMASK_WIDTH   mask bits (derived)
//  OUT_REG      0    1 = extra output register stage (read latency 2, else 1)
//  INIT_CLEAR   1    1 = zero every word after reset, 0 = skip clear (contents X)
// PORTS
//  clk0      in   1            clock, all logic on posedge
//  rst0      in   1            synchronous reset, active-high
//  csb0      in   1            port 0 chip select, active-low
//  web0      in   1            port 0 write enable, active-low (1 = read)
//  wmask0    in   NUM_WMASKS   port 0 slice enables, bit i covers din0[i*WMASK_WIDTH +: WMASK_WIDTH]
//  addr0     in   ADDR_WIDTH   port 0 address
//  din0      in   DATA_WIDTH   port 0 write data
//  dout0     out  DATA_WIDTH   port 0 read data
//  dvalid0   out  1            dout0 carries fresh read data this cycle
//  csb1      in   1            port 1 chip select, active-low (read only)
//  addr1     in   ADDR_WIDTH   port 1 address
//  dout1     out  DATA_WIDTH   port 1 read data
//  dvalid1   out  1            dout1 carries fresh read data this cycle
//  init_done out  1            array ready; requests accepted only when 1
// BEHAVIOUR
//  - Reset (rst0=1 at edge): dout0/dout1=0, dvalid0/dvalid1=0, init_done=0, clear counter=0, pipeline regs cleared.
//  - FSM: CLEAR -> READY. rst0 forces CLEAR (INIT_CLEAR=1) or READY (INIT_CLEAR=0) on next edge.
//    CLEAR: one word written to 0 per cycle at counter address, counter++; after writing RAM_DEPTH-1 -> READY, init_done=1.
//    Clear of RAM_DEPTH words takes exactly RAM_DEPTH cycles after rst0 deasserts.
//  - During CLEAR all port requests ignored: no writes, dout held, dvalid=0. Reset mid-clear restarts at address 0.
//  - Port 0 write (READY, csb0=0, web0=0) at edge N: slices with wmask0[i]=1 updated, others kept; wmask0=0 is a no-op.
//    Write does not touch dout0; dvalid0=0 for that slot.
//  - Port 0 read (csb0=0, web0=1) at edge N: dout0 = mem[addr0], dvalid0=1 after edge N+1 (OUT_REG=0) or N+2 (OUT_REG=1).
//  - Port 1 read (csb1=0) identical timing to port 0 read.
//  - Idle cycle (csb=1): dout held, dvalid=0 in the matching slot.
//  - Collision: port 1 reads the address port 0 writes in the same cycle -> port 1 returns OLD data (read-before-write).
//  - Back-to-back write then read of same address on port 0: read returns newly written data.
//  - Addresses >= RAM_DEPTH (non-power-of-2 depth): writes dropped, reads return 0 with dvalid=1.
//  - dvalid pipeline follows OUT_REG exactly so data/valid stay aligned.
// STRUCTURE
//  - Shared package sram_pkg: FSM state enum (ST_CLEAR, ST_READY), mask-expansion function (NUM_WMASKS -> DATA_WIDTH bit mask).
//  - One sub-module sram_out_stage: per-port output register + valid pipeline, instantiated twice, bypassed when OUT_REG=0.
//  - Array, write-mask merge and clear FSM live in the top.
// TESTING
//  1 Reset then wait: rst0 high 2 cycles, DEPTH=128 -> init_done rises exactly 128 cycles after release; read all -> 0.
//  2 Masked write: write 0xFFFFFFFF to addr 5, then 0x12345678 mask 4'b0101 -> read addr 5 = 0xFF34FF78, dvalid0=1 one cycle later.
//  3 Collision: port 0 writes 0xA5A5A5A5 to addr 9 (old 0) while port 1 reads addr 9 -> dout1=0; next read port 1 -> 0xA5A5A5A5.
//  4 Requests during CLEAR: write 0xDEAD to addr 3 at cycle 10 after reset -> ignored, addr 3 reads 0 after init_done.
//  5 Reset mid-clear: assert rst0 at clear count 60 -> init_done stays 0, rises 128 cycles after second release.
//  6 OUT_REG=1: back-to-back port 1 reads addr 1,2,3 (0x11,0x22,0x33) -> dout1 sequence appears 2 cycles later, dvalid1 high 3 cycles.

Source files
------------

// File: rtl/sram_1rw1r_wmask_pkg.sv
// sram_pkg: shared clear-FSM state type and write-mask expansion helper.
package sram_pkg;
  typedef enum logic {ST_CLEAR, ST_READY} state_t;
  localparam int MAX_BITS = 256;
  function automatic logic [MAX_BITS-1:0] expand_mask(input logic [MAX_BITS-1:0] m, input int unsigned w);
    logic [MAX_BITS-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_BITS; i++) r[8'(i)] = m[8'(i / w)];
    return r;
  endfunction
endpackage

// File: rtl/sram_1rw1r_wmask_if.sv
// sram_1rw1r_wmask_if: port 0 (rw, masked) and port 1 (ro) request/response bundle.
// Ports: csb0/web0/wmask0/addr0/din0 -> dout0/dvalid0; csb1/addr1 -> dout1/dvalid1; init_done.
interface sram_1rw1r_wmask_if import sram_pkg::*; #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 7,
  parameter int WMASK_WIDTH = 8
);
  logic                                csb0, web0, csb1;
  logic [DATA_WIDTH/WMASK_WIDTH-1:0]   wmask0;
  logic [ADDR_WIDTH-1:0]               addr0, addr1;
  logic [DATA_WIDTH-1:0]               din0, dout0, dout1;
  logic                                dvalid0, dvalid1, init_done;
  modport master (output csb0, web0, wmask0, addr0, din0, csb1, addr1,
                  input  dout0, dvalid0, dout1, dvalid1, init_done);
  modport slave  (input  csb0, web0, wmask0, addr0, din0, csb1, addr1,
                  output dout0, dvalid0, dout1, dvalid1, init_done);
endinterface

// File: rtl/sram_1rw1r_wmask_out_stage.sv
// sram_out_stage: registered read data + valid, with an optional second register stage.
// Ports: clk, rst, rd_i (read accepted), data_i (array word) -> dout_o, dvalid_o.
module sram_out_stage import sram_pkg::*; #(
  parameter int DATA_WIDTH = 32,
  parameter int OUT_REG    = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] dout_o,
  output logic                  dvalid_o
);
  logic [DATA_WIDTH-1:0] d1_q;
  logic                  v1_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      d1_q <= '0;
      v1_q <= 1'b0;
    end else begin
      v1_q <= rd_i;
      if (rd_i) d1_q <= data_i;
    end
  end
  if (OUT_REG != 0) begin : g_reg
    logic [DATA_WIDTH-1:0] d2_q;
    logic                  v2_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        d2_q <= '0;
        v2_q <= 1'b0;
      end else begin
        d2_q <= d1_q;
        v2_q <= v1_q;
      end
    end
    assign dout_o   = d2_q;
    assign dvalid_o = v2_q;
  end else begin : g_byp
    assign dout_o   = d1_q;
    assign dvalid_o = v1_q;
  end
endmodule

// File: rtl/sram_1rw1r_wmask.sv
// sram_1rw1r_wmask: 1rw (byte-masked) + 1r synchronous SRAM with post-reset zero clear.
// Ports: clk0, rst0 (sync, active-high), bus (slave side of sram_1rw1r_wmask_if).
module sram_1rw1r_wmask import sram_pkg::*; #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 7,
  parameter int RAM_DEPTH   = 1 << ADDR_WIDTH,
  parameter int WMASK_WIDTH = 8,
  parameter int OUT_REG     = 0,
  parameter int INIT_CLEAR  = 1
) (
  input logic clk0,
  input logic rst0,
  sram_1rw1r_wmask_if.slave bus
);
  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];
  logic [DATA_WIDTH-1:0] bm, rdata0, rdata1;
  logic                  clearing, ok0, ok1, rd0, rd1, wr0;
  assign clearing = state_q == ST_CLEAR;
  assign ok0      = int'(bus.addr0) < RAM_DEPTH;
  assign ok1      = int'(bus.addr1) < RAM_DEPTH;
  assign rd0      = !clearing && !bus.csb0 && bus.web0;
  assign rd1      = !clearing && !bus.csb1;
  assign wr0      = !rst0 && !clearing && !bus.csb0 && !bus.web0 && ok0;
  assign bm       = DATA_WIDTH'(expand_mask(MAX_BITS'(bus.wmask0), WMASK_WIDTH));
  assign rdata0   = ok0 ? mem[bus.addr0] : '0;
  assign rdata1   = ok1 ? mem[bus.addr1] : '0;
  assign bus.init_done = state_q == ST_READY;
  always_comb begin
    state_d = clearing && cnt_q == ADDR_WIDTH'(RAM_DEPTH - 1) ? ST_READY : state_q;
    cnt_d   = clearing ? cnt_q + ADDR_WIDTH'(1) : cnt_q;
  end
  always_ff @(posedge clk0) begin
    if (rst0) begin
      state_q <= INIT_CLEAR != 0 ? ST_CLEAR : ST_READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // Array has no reset; the clear walk zeroes one word per cycle instead.
  // Port 1 samples the array with the same edge as the write, so a collision reads old data.
  always_ff @(posedge clk0) begin
    if (!rst0 && clearing) mem[cnt_q] <= '0;
    else if (wr0) mem[bus.addr0] <= (mem[bus.addr0] & ~bm) | (bus.din0 & bm);
  end
  sram_out_stage #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_out0 (
    .clk(clk0), .rst(rst0), .rd_i(rd0), .data_i(rdata0), .dout_o(bus.dout0), .dvalid_o(bus.dvalid0));
  sram_out_stage #(.DATA_WIDTH(DATA_WIDTH), .OUT_REG(OUT_REG)) u_out1 (
    .clk(clk0), .rst(rst0), .rd_i(rd1), .data_i(rdata1), .dout_o(bus.dout1), .dvalid_o(bus.dvalid1));
endmodule

// File: tb/tb_sram_1rw1r_wmask.sv
// tb_sram_1rw1r_wmask: two instances (depth 128/latency 1, depth 100/latency 2) against a behavioural model.
module tb_sram_1rw1r_wmask;
  logic clk = 1'b0;
  logic rst, csb0, web0, csb1;
  logic [3:0]  wmask0;
  logic [6:0]  addr0, addr1;
  logic [31:0] din0;
  int checks = 0, errors = 0;
  bit started = 0;
  always #5 clk = ~clk;

  sram_1rw1r_wmask_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .WMASK_WIDTH(8)) b0 ();
  sram_1rw1r_wmask_if #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .WMASK_WIDTH(8)) b1 ();
  assign b0.csb0 = csb0;   assign b1.csb0 = csb0;
  assign b0.web0 = web0;   assign b1.web0 = web0;
  assign b0.wmask0 = wmask0; assign b1.wmask0 = wmask0;
  assign b0.addr0 = addr0; assign b1.addr0 = addr0;
  assign b0.din0 = din0;   assign b1.din0 = din0;
  assign b0.csb1 = csb1;   assign b1.csb1 = csb1;
  assign b0.addr1 = addr1; assign b1.addr1 = addr1;

  sram_1rw1r_wmask #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .RAM_DEPTH(128), .WMASK_WIDTH(8), .OUT_REG(0), .INIT_CLEAR(1))
    u0 (.clk0(clk), .rst0(rst), .bus(b0));
  sram_1rw1r_wmask #(.DATA_WIDTH(32), .ADDR_WIDTH(7), .RAM_DEPTH(100), .WMASK_WIDTH(8), .OUT_REG(1), .INIT_CLEAR(1))
    u1 (.clk0(clk), .rst0(rst), .bus(b1));

  // Behavioural model: the clear is a countdown after which the whole array is zero.
  logic [31:0] mem [2][128];
  int          clear_left [2];
  logic [31:0] s1d0 [2], s1d1 [2], s2d0 [2], s2d1 [2];
  bit          s1v0 [2], s1v1 [2], s2v0 [2], s2v1 [2];
  bit          rdy;

  function automatic int dep(input int k);
    return k == 0 ? 128 : 100;
  endfunction
  function automatic logic [31:0] peek(input int k, input logic [6:0] a);
    return int'(a) < dep(k) ? mem[k][a] : 32'h0;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        clear_left[k] = dep(k);
        s1d0[k] = 0; s1d1[k] = 0; s2d0[k] = 0; s2d1[k] = 0;
        s1v0[k] = 0; s1v1[k] = 0; s2v0[k] = 0; s2v1[k] = 0;
      end else begin
        s2d0[k] = s1d0[k]; s2v0[k] = s1v0[k]; s2d1[k] = s1d1[k]; s2v1[k] = s1v1[k];
        rdy = clear_left[k] == 0;
        s1v0[k] = rdy && !csb0 && web0;
        s1v1[k] = rdy && !csb1;
        if (s1v0[k]) s1d0[k] = peek(k, addr0);
        if (s1v1[k]) s1d1[k] = peek(k, addr1);
        if (rdy && !csb0 && !web0 && int'(addr0) < dep(k))
          for (int s = 0; s < 4; s++) if (wmask0[s]) mem[k][addr0][s*8 +: 8] = din0[s*8 +: 8];
        if (clear_left[k] > 0) begin
          clear_left[k]--;
          if (clear_left[k] == 0) for (int i = 0; i < 128; i++) mem[k][i] = 32'h0;
        end
      end
    end
    if (rst) started = 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (started) begin
    check("u0.dout0",   b0.dout0,         s1d0[0]);
    check("u0.dvalid0", 32'(b0.dvalid0),  32'(s1v0[0]));
    check("u0.dout1",   b0.dout1,         s1d1[0]);
    check("u0.dvalid1", 32'(b0.dvalid1),  32'(s1v1[0]));
    check("u0.init",    32'(b0.init_done), 32'(clear_left[0] == 0));
    check("u1.dout0",   b1.dout0,         s2d0[1]);
    check("u1.dvalid0", 32'(b1.dvalid0),  32'(s2v0[1]));
    check("u1.dout1",   b1.dout1,         s2d1[1]);
    check("u1.dvalid1", 32'(b1.dvalid1),  32'(s2v1[1]));
    check("u1.init",    32'(b1.init_done), 32'(clear_left[1] == 0));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle;
    csb0 = 1; web0 = 1; csb1 = 1; wmask0 = 0; addr0 = 0; addr1 = 0; din0 = 0;
  endtask
  task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] m);
    csb0 = 0; web0 = 0; addr0 = a; din0 = d; wmask0 = m;
  endtask
  task automatic rd0(input logic [6:0] a);
    csb0 = 0; web0 = 1; addr0 = a;
  endtask
  // Counts edges after reset release until u0 reports ready; optionally pokes a write at edge 10.
  task automatic wait_init(input bit poke, output int n);
    n = 0;
    while (!b0.init_done && n < 300) begin
      if (poke && n == 9) wr(7'd3, 32'hDEAD, 4'hF); else idle();
      tick();
      n++;
    end
    idle();
  endtask

  int n;
  logic [31:0] seq [3];
  initial begin
    idle();
    rst = 1;
    tick(); tick();
    rst = 0;
    wait_init(1, n);
    check("init_latency", n, 128);
    // Reset in the middle of the clear restarts it from word 0.
    rst = 1; tick(); tick(); rst = 0;
    for (int i = 0; i < 60; i++) tick();
    check("midclear_init_low", 32'(b0.init_done), 0);
    rst = 1; tick(); rst = 0;
    wait_init(0, n);
    check("midclear_latency", n, 128);
    rd0(7'd3); tick(); idle();
    check("clear_write_ignored", b0.dout0, 32'h0);
    for (int a = 0; a < 128; a++) begin
      rd0(7'(a)); csb1 = 0; addr1 = 7'(127 - a);
      tick();
      check("cleared_p0", b0.dout0, 32'h0);
      check("cleared_p1", b0.dout1, 32'h0);
    end
    idle();
    wr(7'd5, 32'hFFFFFFFF, 4'hF); tick();
    wr(7'd5, 32'h12345678, 4'b0101); tick();
    idle(); rd0(7'd5); tick();
    check("mask_data", b0.dout0, 32'hFF34FF78);
    check("mask_valid", 32'(b0.dvalid0), 1);
    idle();
    wr(7'd9, 32'hA5A5A5A5, 4'hF); csb1 = 0; addr1 = 7'd9; tick();
    check("collision_old", b0.dout1, 32'h0);
    idle(); csb1 = 0; addr1 = 7'd9; tick();
    check("collision_new", b0.dout1, 32'hA5A5A5A5);
    idle();
    seq = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) begin wr(7'(i + 1), seq[i], 4'hF); tick(); end
    idle();
    for (int i = 0; i < 5; i++) begin
      if (i < 3) begin csb1 = 0; addr1 = 7'(i + 1); end else csb1 = 1;
      tick();
      if (i >= 1 && i <= 3) begin
        check("outreg_data", b1.dout1, seq[i-1]);
        check("outreg_valid", 32'(b1.dvalid1), 1);
      end
      if (i == 0 || i == 4) check("outreg_valid_low", 32'(b1.dvalid1), 0);
    end
    wr(7'd110, 32'hCAFEF00D, 4'hF); tick();
    idle(); rd0(7'd110); tick();
    idle(); tick();
    check("oor_data", b1.dout0, 32'h0);
    check("oor_valid", 32'(b1.dvalid0), 1);
    for (int c = 0; c < 3000; c++) begin
      rst    = $urandom_range(0, 999) == 0;
      csb0   = $urandom_range(0, 3) == 0;
      web0   = 1'($urandom_range(0, 1));
      wmask0 = 4'($urandom_range(0, 15));
      din0   = $urandom;
      addr0  = $urandom_range(0, 1) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(0, 127));
      csb1   = $urandom_range(0, 3) == 0;
      addr1  = $urandom_range(0, 1) ? 7'($urandom_range(0, 15)) : 7'($urandom_range(0, 127));
      tick();
    end
    rst = 0; idle(); tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
